// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - IF/ID pipeline register with stall-hold of the SRAM read word
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   stall           pipeline stall vector; [1] = IF/ID hold, [2] = ID/EX hold
//   flush           kill request from exception logic
//   if_to_id_bus    {ce, pc} registered in the fetch stage
//   inst_sram_rdata instruction SRAM read data, valid one cycle after address
//   id_bus          {id_valid, id_pc, id_inst} to decode
//   hold_active     high while a held instruction word is being used

`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module if_id_buffer #(
    parameter int PC_WD   = 32,
    parameter int INST_WD = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [`StallBus]          stall,
    input  logic                      flush,
    input  logic [PC_WD:0]            if_to_id_bus,
    input  logic [INST_WD-1:0]        inst_sram_rdata,
    output logic [PC_WD+INST_WD:0]    id_bus,
    output logic                      hold_active
);

    logic               v_q;
    logic [PC_WD-1:0]   pc_q;
    logic               hold_v;
    logic [INST_WD-1:0] hold_inst;

    logic               ce;
    logic [PC_WD-1:0]   pc;

    assign ce = if_to_id_bus[PC_WD];
    assign pc = if_to_id_bus[PC_WD-1:0];

    logic is_flush;
    logic is_bubble;
    logic is_advance;

    // Priority: flush, then bubble (IF/ID stalled while ID/EX moves on),
    // then advance; anything left is a hold.
    assign is_flush   = flush;
    assign is_bubble  = (stall[1] == `Stop) && (stall[2] == `NoStop);
    assign is_advance = (stall[1] == `NoStop);

    always_ff @(posedge clk) begin
        if (rst || is_flush || is_bubble) begin
            v_q       <= 1'b0;
            pc_q      <= '0;
            hold_v    <= 1'b0;
            hold_inst <= '0;
        end else if (is_advance) begin
            v_q    <= ce;
            pc_q   <= pc;
            hold_v <= 1'b0;
        end else if (!hold_v) begin
            // The SRAM word for the current pc is only on rdata this cycle;
            // capture it on the first stalled edge and keep it thereafter.
            hold_v    <= 1'b1;
            hold_inst <= inst_sram_rdata;
        end
    end

    logic [INST_WD-1:0] id_inst;

    always_comb begin
        id_inst = '0;
        if (v_q) begin
            id_inst = hold_v ? hold_inst : inst_sram_rdata;
        end
    end

    assign id_bus      = {v_q, pc_q, id_inst};
    assign hold_active = hold_v;

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter PC_WD, default 32, program-counter width.
REQ-002 SHALL have parameter INST_WD, default 32, instruction word width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port stall, input, `StallBus, pipeline stall vector; stall[1] is the IF/ID hold request and stall[2] is the ID/EX hold request; compare against `Stop/`NoStop.
REQ-007 SHALL have port flush, input, 1, kill request from the exception logic.
REQ-008 SHALL have port if_to_id_bus, input, 1+PC_WD, {ce, pc} from the fetch stage, registered in the fetch stage.
REQ-009 SHALL have port inst_sram_rdata, input, INST_WD, instruction SRAM read data; valid one cycle after the address is presented.
REQ-010 SHALL have port id_bus, output, 1+PC_WD+INST_WD, {id_valid, id_pc, id_inst} to decode.
REQ-011 SHALL have port hold_active, output, 1, high while a held instruction is in use.

Function
REQ-012 SHALL hold internal registers v_q (1 bit), pc_q (PC_WD), hold_v (1 bit) and hold_inst (INST_WD).
REQ-013 SHALL classify each cycle with this priority: FLUSH when flush=1; BUBBLE when stall[1]=`Stop and stall[2]=`NoStop; ADVANCE when stall[1]=`NoStop; otherwise HOLD.
REQ-014 On FLUSH or BUBBLE at the clock edge, SHALL set v_q=0, pc_q=0, hold_v=0 and hold_inst=0.
REQ-015 On ADVANCE at the clock edge, SHALL set v_q=ce and pc_q=pc from if_to_id_bus, and set hold_v=0.
REQ-016 On HOLD at the clock edge with hold_v=0, SHALL set hold_v=1 and hold_inst=inst_sram_rdata; v_q and pc_q are unchanged.
REQ-017 On HOLD at the clock edge with hold_v=1, SHALL leave all registers unchanged, so the first-captured word is kept across multi-cycle stalls.
REQ-018 id_valid SHALL equal v_q.
REQ-019 id_pc SHALL equal pc_q.
REQ-020 id_inst SHALL be combinational: 0 when v_q=0; hold_inst when v_q=1 and hold_v=1; otherwise inst_sram_rdata.
REQ-021 hold_active SHALL equal hold_v.
REQ-022 Latency: a pc accepted on ADVANCE at edge N SHALL appear on id_pc after edge N, with its instruction on id_inst in that same cycle (zero added latency over the SRAM).
REQ-023 An ADVANCE with ce=0 SHALL produce id_valid=0 and id_inst=0 regardless of inst_sram_rdata.
REQ-024 flush SHALL override any stall value in the same cycle.
REQ-025 When HOLD begins with v_q=0, hold_inst SHALL still be captured, and id_inst SHALL remain 0.
REQ-026 Going from HOLD directly to ADVANCE SHALL clear hold_v at that edge, with the new pc taking effect after the edge; the held word is never presented alongside the new pc.

Reset
REQ-027 While rst=1 at a clock edge, SHALL set v_q=0, pc_q=0, hold_v=0 and hold_inst=0, with priority over flush and stall.
REQ-028 After reset, outputs SHALL be id_valid=0, id_pc=0, id_inst=0 and hold_active=0.
REQ-029 rst asserted during a HOLD SHALL discard the held instruction.

Verification
REQ-030 Reset then ADVANCE with {1, 0xBFC00000}, rdata=0x3C08BFAF next cycle -> id_bus={1, 0xBFC00000, 0x3C08BFAF}, hold_active=0.
REQ-031 Valid pc 0xBFC00004, rdata 0x24090001; HOLD 3 cycles while rdata changes to 0xFFFFFFFF -> id_inst stays 0x24090001, hold_active=1 for cycles 2-3.
REQ-032 stall[1]=Stop and stall[2]=NoStop with a valid entry -> next cycle id_valid=0, id_pc=0, id_inst=0.
REQ-033 flush=1 together with stall=all-Stop -> next cycle id_valid=0, hold_active=0.
REQ-034 ADVANCE with ce=0, pc=0xBFBFFFFC, rdata=0x12345678 -> id_valid=0, id_inst=0, id_pc=0xBFBFFFFC.
REQ-035 rst=1 in the middle of a HOLD, then ADVANCE {1, 0xBFC00008} with rdata 0x00000000 -> id_inst=0x00000000, not the previously held word.
